// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: captures operands and control, inserts
// load-use bubbles while stalling fetch/decode, and forwards EX/MEM and MEM/WB results.
module id_ex_stage #(
    parameter int CTL_W      = 8,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [31:0]       id_data1,
    input  logic [31:0]       id_data2,
    input  logic [4:0]        id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [31:0]       id_imm,
    input  logic [CTL_W-1:0]  id_ctl,
    input  logic              flush,
    input  logic              mem_regwrite,
    input  logic [4:0]        mem_wrreg,
    input  logic [31:0]       mem_result,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_wrreg,
    input  logic [31:0]       wb_result,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [31:0]       ex_imm,
    output logic [CTL_W-1:0]  ex_ctl,
    output logic [31:0]       ex_opa,
    output logic [31:0]       ex_opb,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [2:0]        dbg_scnt
);

    localparam logic [2:0] SCNT_RELOAD = 3'(LOAD_STALL - 1);

    logic [31:0] ex_data1;
    logic [31:0] ex_data2;
    logic [2:0]  scnt;
    logic        hazard;

    // A load in EX whose destination feeds the decode slot must wait for memory.
    assign hazard = id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

    // A taken branch kills the decode slot, so there is nothing left to hold.
    assign stall_out = !flush && (hazard || (scnt != 3'd0));
    assign dbg_scnt  = scnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_imm      <= '0;
            ex_ctl      <= '0;
            ex_data1    <= '0;
            ex_data2    <= '0;
            scnt        <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            scnt        <= '0;
        end else if (hazard && (scnt == 3'd0)) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            scnt        <= SCNT_RELOAD;
        end else if (scnt != 3'd0) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            scnt        <= scnt - 3'd1;
        end else begin
            // Side-effect flags are qualified so a captured non-instruction stays inert.
            ex_valid    <= id_valid;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_regwrite <= id_regwrite && id_valid;
            ex_memread  <= id_memread && id_valid;
            ex_imm      <= id_imm;
            ex_ctl      <= id_ctl;
            ex_data1    <= id_data1;
            ex_data2    <= id_data2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_out && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // EX/MEM is younger than MEM/WB, so it is checked first; r0 is hardwired to zero.
    always_comb begin
        ex_opa = ex_data1;
        if (ex_rs == 5'd0)
            ex_opa = '0;
        else if (mem_regwrite && (mem_wrreg == ex_rs))
            ex_opa = mem_result;
        else if (wb_regwrite && (wb_wrreg == ex_rs))
            ex_opa = wb_result;
    end

    always_comb begin
        ex_opb = ex_data2;
        if (ex_rt == 5'd0)
            ex_opb = '0;
        else if (mem_regwrite && (mem_wrreg == ex_rt))
            ex_opb = mem_result;
        else if (wb_regwrite && (wb_wrreg == ex_rt))
            ex_opb = wb_result;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: instance a uses LOAD_STALL=1/CNT_W=16, instance b
// uses LOAD_STALL=3/CNT_W=4; both share the same stimulus.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_data1, id_data2, id_imm;
    logic        id_regwrite, id_memread;
    logic [7:0]  id_ctl;
    logic        flush;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_wrreg, wb_wrreg;
    logic [31:0] mem_result, wb_result;

    logic        stall_out, ex_valid, ex_regwrite, ex_memread;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_imm, ex_opa, ex_opb;
    logic [7:0]  ex_ctl;
    logic [15:0] stall_cycles;
    logic [2:0]  dbg_scnt;

    logic        b_stall_out, b_ex_valid, b_ex_regwrite, b_ex_memread;
    logic [4:0]  b_ex_rs, b_ex_rt, b_ex_rd;
    logic [31:0] b_ex_imm, b_ex_opa, b_ex_opb;
    logic [7:0]  b_ex_ctl;
    logic [3:0]  b_stall_cycles;
    logic [2:0]  b_dbg_scnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CTL_W(8), .LOAD_STALL(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_data1(id_data1), .id_data2(id_data2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_imm(id_imm), .id_ctl(id_ctl), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_wrreg(mem_wrreg), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_wrreg(wb_wrreg), .wb_result(wb_result),
        .stall_out(stall_out), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_imm(ex_imm),
        .ex_ctl(ex_ctl), .ex_opa(ex_opa), .ex_opb(ex_opb), .stall_cycles(stall_cycles),
        .dbg_scnt(dbg_scnt)
    );

    id_ex_stage #(.CTL_W(8), .LOAD_STALL(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_data1(id_data1), .id_data2(id_data2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_imm(id_imm), .id_ctl(id_ctl), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_wrreg(mem_wrreg), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_wrreg(wb_wrreg), .wb_result(wb_result),
        .stall_out(b_stall_out), .ex_valid(b_ex_valid), .ex_rs(b_ex_rs), .ex_rt(b_ex_rt),
        .ex_rd(b_ex_rd), .ex_regwrite(b_ex_regwrite), .ex_memread(b_ex_memread),
        .ex_imm(b_ex_imm), .ex_ctl(b_ex_ctl), .ex_opa(b_ex_opa), .ex_opb(b_ex_opb),
        .stall_cycles(b_stall_cycles), .dbg_scnt(b_dbg_scnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic rw, input logic mr,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [7:0] ctl);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_data1    = d1;
        id_data2    = d2;
        id_imm      = imm;
        id_ctl      = ctl;
    endtask

    task automatic clear_fwd();
        mem_regwrite = 1'b0;
        mem_wrreg    = 5'd0;
        mem_result   = 32'd0;
        wb_regwrite  = 1'b0;
        wb_wrreg     = 5'd0;
        wb_result    = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        clear_fwd();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        clear_fwd();
        drive_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7, 8'h8);
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0h exp 0", ex_valid); end
        checks++; if (ex_opa !== 32'd0) begin errors++; $display("FAIL reset_ex_opa got %0h exp 0", ex_opa); end
        checks++; if (ex_opb !== 32'd0) begin errors++; $display("FAIL reset_ex_opb got %0h exp 0", ex_opb); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall_out got %0h exp 0", stall_out); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_cycles got %0h exp 0", stall_cycles); end
        checks++; if (ex_imm !== 32'd0 || ex_ctl !== 8'd0) begin errors++; $display("FAIL reset_ex_data got imm=%0h ctl=%0h exp 0", ex_imm, ex_ctl); end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'h100, 32'h0, 32'h4, 8'h11);
        tick();
        drive_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 32'hAAAA, 32'h2, 32'h0, 8'h22);
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall_detect got %0h exp 1", stall_out); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0) begin errors++; $display("FAIL lu_bubble got v=%0h rw=%0h mr=%0h exp 0 0 0", ex_valid, ex_regwrite, ex_memread); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lu_stall_end got %0h exp 0", stall_out); end
        checks++; if (ex_rd !== 5'd5 || ex_imm !== 32'h4) begin errors++; $display("FAIL lu_bubble_hold got rd=%0h imm=%0h exp 5 4", ex_rd, ex_imm); end
        id_data1 = 32'h1234;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_rs !== 5'd5) begin errors++; $display("FAIL lu_capture got v=%0h rd=%0h rs=%0h exp 1 7 5", ex_valid, ex_rd, ex_rs); end
        checks++; if (ex_opa !== 32'h1234 || ex_opb !== 32'h2) begin errors++; $display("FAIL lu_operands got a=%0h b=%0h exp 1234 2", ex_opa, ex_opb); end
        checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_stall_cycles got %0d exp 1", stall_cycles); end
    endtask

    task automatic test_multi_cycle();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'h100, 32'h0, 32'h4, 8'h11);
        tick();
        drive_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 32'h1, 32'h2, 32'h0, 8'h22);
        #1;
        checks++; if (b_stall_out !== 1'b1) begin errors++; $display("FAIL mc_detect got %0h exp 1", b_stall_out); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (b_ex_valid !== 1'b0) begin errors++; $display("FAIL mc_bubble%0d got %0h exp 0", i, b_ex_valid); end
            checks++; if (b_stall_out !== (i < 3)) begin errors++; $display("FAIL mc_stall%0d got %0h exp %0h", i, b_stall_out, (i < 3)); end
        end
        tick();
        checks++; if (b_ex_valid !== 1'b1 || b_ex_rd !== 5'd7) begin errors++; $display("FAIL mc_capture got v=%0h rd=%0h exp 1 7", b_ex_valid, b_ex_rd); end
        checks++; if (b_stall_cycles !== 4'd3) begin errors++; $display("FAIL mc_stall_cycles got %0d exp 3", b_stall_cycles); end
    endtask

    task automatic test_forwarding();
        do_reset();
        drive_id(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 32'h11, 32'h44, 32'h0, 8'h0);
        tick();
        mem_regwrite = 1'b1; mem_wrreg = 5'd3; mem_result = 32'h22;
        wb_regwrite  = 1'b1; wb_wrreg  = 5'd3; wb_result  = 32'h33;
        #1;
        checks++; if (ex_opa !== 32'h22) begin errors++; $display("FAIL fwd_mem_priority got %0h exp 22", ex_opa); end
        checks++; if (ex_opb !== 32'h44) begin errors++; $display("FAIL fwd_b_none got %0h exp 44", ex_opb); end
        mem_regwrite = 1'b0;
        #1;
        checks++; if (ex_opa !== 32'h33) begin errors++; $display("FAIL fwd_wb got %0h exp 33", ex_opa); end
        wb_regwrite = 1'b0;
        #1;
        checks++; if (ex_opa !== 32'h11) begin errors++; $display("FAIL fwd_none got %0h exp 11", ex_opa); end
        mem_regwrite = 1'b1; mem_wrreg = 5'd4; mem_result = 32'h55;
        #1;
        checks++; if (ex_opb !== 32'h55 || ex_opa !== 32'h11) begin errors++; $display("FAIL fwd_b_mem got b=%0h a=%0h exp 55 11", ex_opb, ex_opa); end
        clear_fwd();
    endtask

    task automatic test_reg_zero();
        do_reset();
        drive_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 32'h99, 32'h77, 32'h0, 8'h0);
        tick();
        mem_regwrite = 1'b1; mem_wrreg = 5'd0; mem_result = 32'hFFFF_FFFF;
        wb_regwrite  = 1'b1; wb_wrreg  = 5'd0; wb_result  = 32'hDEAD_BEEF;
        #1;
        checks++; if (ex_opb !== 32'd0) begin errors++; $display("FAIL r0_opb got %0h exp 0", ex_opb); end
        checks++; if (ex_opa !== 32'd0) begin errors++; $display("FAIL r0_opa got %0h exp 0", ex_opa); end
        clear_fwd();
        drive_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 8'h0);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL r0_no_hazard got %0h exp 0", stall_out); end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 8'h0);
        tick();
        drive_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 32'h1, 32'h2, 32'h0, 8'h0);
        flush = 1'b1;
        #1;
        checks++; if (stall_out !== 1'b0 || b_stall_out !== 1'b0) begin errors++; $display("FAIL fl_stall got a=%0h b=%0h exp 0 0", stall_out, b_stall_out); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || b_ex_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got a=%0h b=%0h exp 0 0", ex_valid, b_ex_valid); end
        checks++; if (b_dbg_scnt !== 3'd0 || dbg_scnt !== 3'd0) begin errors++; $display("FAIL fl_scnt got a=%0h b=%0h exp 0 0", dbg_scnt, b_dbg_scnt); end
        checks++; if (stall_out !== 1'b0 || b_stall_out !== 1'b0) begin errors++; $display("FAIL fl_after got a=%0h b=%0h exp 0 0", stall_out, b_stall_out); end
        tick();
        checks++; if (b_ex_valid !== 1'b1 || b_ex_rd !== 5'd7) begin errors++; $display("FAIL fl_recapture got v=%0h rd=%0h exp 1 7", b_ex_valid, b_ex_rd); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 8'h0);
        tick();
        drive_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 32'h0, 32'h0, 32'h8, 8'h0);
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL b2b_first got %0h exp 1", stall_out); end
        tick();
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL b2b_bubble got %0h exp 0", stall_out); end
        tick();
        checks++; if (ex_rd !== 5'd6 || ex_memread !== 1'b1) begin errors++; $display("FAIL b2b_load2 got rd=%0h mr=%0h exp 6 1", ex_rd, ex_memread); end
        drive_id(1'b1, 5'd2, 5'd6, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL b2b_second got %0h exp 1", stall_out); end
        tick();
        tick();
        checks++; if (ex_rd !== 5'd7 || ex_memread !== 1'b0 || ex_regwrite !== 1'b1) begin errors++; $display("FAIL b2b_use got rd=%0h mr=%0h rw=%0h exp 7 0 1", ex_rd, ex_memread, ex_regwrite); end
        checks++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", stall_cycles); end
    endtask

    task automatic test_saturation();
        do_reset();
        // lw r5, 0(r5): each re-capture re-triggers its own hazard.
        drive_id(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 8'h0);
        repeat (20) tick();
        checks++; if (stall_cycles !== 16'd10) begin errors++; $display("FAIL sat_a20 got %0d exp 10", stall_cycles); end
        checks++; if (b_stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_b20 got %0d exp 15", b_stall_cycles); end
        repeat (20) tick();
        checks++; if (stall_cycles !== 16'd20) begin errors++; $display("FAIL sat_a40 got %0d exp 20", stall_cycles); end
        checks++; if (b_stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_b40 got %0d exp 15", b_stall_cycles); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'h0, 32'h0, 32'h10, 8'h5A);
        tick();
        drive_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 32'h66, 32'h2, 32'h20, 8'hA5);
        tick();
        tick();
        checks++; if (b_dbg_scnt !== 3'd1 || ex_valid !== 1'b1) begin errors++; $display("FAIL rms_pre got scnt=%0h v=%0h exp 1 1", b_dbg_scnt, ex_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_rs !== 5'd0) begin errors++; $display("FAIL rms_a_ctl got v=%0h rd=%0h rs=%0h exp 0 0 0", ex_valid, ex_rd, ex_rs); end
        checks++; if (ex_imm !== 32'd0 || ex_ctl !== 8'd0 || ex_opa !== 32'd0) begin errors++; $display("FAIL rms_a_data got imm=%0h ctl=%0h opa=%0h exp 0 0 0", ex_imm, ex_ctl, ex_opa); end
        checks++; if (stall_cycles !== 16'd0 || b_stall_cycles !== 4'd0) begin errors++; $display("FAIL rms_count got a=%0d b=%0d exp 0 0", stall_cycles, b_stall_cycles); end
        checks++; if (b_stall_out !== 1'b0 || b_dbg_scnt !== 3'd0 || b_ex_rd !== 5'd0) begin errors++; $display("FAIL rms_b got st=%0h scnt=%0h rd=%0h exp 0 0 0", b_stall_out, b_dbg_scnt, b_ex_rd); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multi_cycle();
        test_forwarding();
        test_reg_zero();
        test_flush_hazard();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
